// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem reads feeding a prefetch FIFO.
// Define FETCH_BYPASS_EN to forward a response straight to the decoder when the FIFO is empty.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_load,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ready,
  output logic              increm_pc,
  output logic              fetch_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [ADDR_W-1:0] fetch_addr_inc;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            head;
  logic              ack_in_req, fifo_valid, bypass, push, fifo_pop;

  // req_addr_q is the address actually on the bus; fetch_addr_q may already hold a redirect target.
  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = req_addr_q;
  assign fetch_busy = (state_q != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    ack_in_req  = (state_q == REQ) && imem_ack;
    fifo_valid  = (count_q != '0);
    head        = mem_q[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
    bypass      = ack_in_req && !fifo_valid && !pc_load;
`else
    bypass      = 1'b0;
`endif
    instr_valid = fifo_valid || bypass;
    instr_addr  = '0;
    instr_data  = '0;
    if (bypass) begin
      instr_addr = req_addr_q;
      instr_data = imem_rdata;
    end else if (fifo_valid) begin
      instr_addr = head.addr;
      instr_data = head.data;
    end

    increm_pc = instr_valid && instr_ready && !pc_load;
    fifo_pop  = increm_pc && fifo_valid;
    push      = ack_in_req && !pc_load && !(bypass && instr_ready);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pc_load) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)     wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_addr_d   = fetch_addr_q;
    req_addr_d     = req_addr_q;
    fetch_addr_inc = fetch_addr_q + ADDR_W'(1);
    unique case (state_q)
      IDLE: begin
        if (pc_load) begin
          fetch_addr_d = pc_in;
          req_addr_d   = pc_in;
          state_d      = REQ;
        end else if (count_d < DEPTH_C) begin
          req_addr_d = fetch_addr_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (pc_load) begin
          fetch_addr_d = pc_in;
          if (imem_ack) begin
            req_addr_d = pc_in;
          end else begin
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          fetch_addr_d = fetch_addr_inc;
          if (count_d < DEPTH_C) begin
            req_addr_d = fetch_addr_inc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (pc_load) fetch_addr_d = pc_in;
        // The stale request completes here; its data is never pushed.
        if (imem_ack) begin
          if (count_d < DEPTH_C) begin
            req_addr_d = fetch_addr_d;
            state_d    = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
      req_addr_q   <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q masks unwritten entries from the outputs.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_addr_q, imem_rdata};
  end

endmodule
